if_queue: RTL

Instruction fetch unit and instruction queue that feeds the decoder. Holds the fetch PC and issues one-word read requests to the memory controller, then buffers returned instruction words with their PCs in a circular FIFO. Presents the FIFO head on the fetch interface (`fetchEmpty_o`, `fetchData_o`, `fetchPc_o`) that the decoder consumes. Sits between the memory controller and ID; the dispatcher pops entries, and ROB/branch logic flushes the queue on redirect.

---
 rtl/if_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/if_queue.sv
// Instruction fetch unit: issues one-word reads at the fetch PC and buffers the
// returned words with their PCs in a circular queue read by the decoder.
module if_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  output logic                     memReq_o,
  output logic [31:0]              memAddr_o,
  input  logic                     memDone_i,
  input  logic [31:0]              memData_i,
  output logic                     fetchEmpty_o,
  output logic [31:0]              fetchData_o,
  output logic [31:0]              fetchPc_o,
  input  logic                     fetchPop_i,
  input  logic                     flush_i,
  input  logic [31:0]              flushPc_i,
  output logic [1:0]               dbg_state_o,
  output logic [$clog2(DEPTH):0]   dbg_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pcs_q  [DEPTH];

  logic            push;
  logic            pop;

  // Memory handshake: memReq_o/memAddr_o stay stable from issue until the
  // cycle memDone_i is sampled high; memDone_i outside WAIT/DROP is ignored.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (rdy) begin
      if (flush_i) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        pc_d    = flushPc_i;
        case (state_q)
          S_WAIT, S_DROP: begin
            if (memDone_i) begin
              mem_req_d = 1'b0;
              state_d   = S_IDLE;
            end else begin
              state_d   = S_DROP;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        pop = fetchPop_i && (count_q != '0);
        case (state_q)
          S_IDLE: begin
            if (count_q < CW'(DEPTH)) begin
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
              state_d    = S_WAIT;
            end
          end
          S_WAIT: begin
            if (memDone_i) begin
              push      = 1'b1;
              pc_d      = pc_q + 32'd4;
              mem_req_d = 1'b0;
              state_d   = S_IDLE;
            end
          end
          S_DROP: begin
            if (memDone_i) begin
              mem_req_d = 1'b0;
              state_d   = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase

        if (pop) begin
          head_d = head_q + PW'(1);
        end
        if (push) begin
          tail_d = tail_q + PW'(1);
        end
        if (push && !pop) begin
          count_d = count_q + CW'(1);
        end else if (pop && !push) begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // The entry PC is the fetch PC, which is still the request address in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else if (push) begin
      data_q[tail_q] <= memData_i;
      pcs_q[tail_q]  <= pc_q;
    end
  end

  assign memReq_o     = mem_req_q;
  assign memAddr_o    = mem_addr_q;
  assign fetchEmpty_o = (count_q == '0);
  assign fetchData_o  = data_q[head_q];
  assign fetchPc_o    = pcs_q[head_q];
  assign dbg_state_o  = state_q;
  assign dbg_count_o  = count_q;

endmodule
